// File: rtl/lowampa_capture_ctrl.sv
// Capture controller: freezes the capture buffers a programmable number of cycles after an accepted trigger.
// Latency: trigger_o one edge after the hit; capture_enable_o falls L+1 edges after trigger_o rises.
// Backpressure: a hit with the capture engine busy or mid-sequence is dropped and counted as missed.
module lowampa_capture_ctrl #(
    parameter int NBEAMS          = 2,
    parameter int CNT_BITS        = 16,
    parameter int TRIG_COUNT_BITS = 32,
    parameter int MISSED_BITS     = 16
) (
    input  logic                       aclk,
    input  logic                       rst_i,
    input  logic [NBEAMS-1:0]          trig_i,
    input  logic [NBEAMS-1:0]          beam_mask_i,
    input  logic                       force_i,
    input  logic                       arm_i,
    input  logic [CNT_BITS-1:0]        posttrig_len_i,
    input  logic [CNT_BITS-1:0]        holdoff_len_i,
    input  logic                       clear_counts_i,
    input  logic                       capture_waiting_i,
    output logic                       capture_enable_o,
    output logic                       trigger_o,
    output logic [NBEAMS-1:0]          trig_beams_o,
    output logic [1:0]                 trig_src_o,
    output logic [2:0]                 state_o,
    output logic [TRIG_COUNT_BITS-1:0] trig_count_o,
    output logic [MISSED_BITS-1:0]     missed_count_o
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_POST     = 3'd2,
        S_FROZEN   = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    state_t                     r_state;
    logic [CNT_BITS-1:0]        r_cnt;
    logic                       r_seen_low;
    logic                       r_capture_enable;
    logic                       r_trigger;
    logic [NBEAMS-1:0]          r_trig_beams;
    logic [1:0]                 r_trig_src;
    logic [TRIG_COUNT_BITS-1:0] r_trig_count;
    logic [MISSED_BITS-1:0]     r_missed_count;

    logic [NBEAMS-1:0] w_beam_hits;
    logic              w_hit;
    logic              w_busy;
    logic              w_accept;
    logic              w_miss;

    assign w_beam_hits = trig_i & beam_mask_i;
    assign w_hit       = (|w_beam_hits) | force_i;
    // Sequence states that cannot take a new trigger
    assign w_busy      = (r_state == S_POST) || (r_state == S_FROZEN) || (r_state == S_HOLDOFF);
    // Disarming in ARMED takes priority over a coincident hit, so such a hit is neither accepted nor counted
    assign w_accept    = (r_state == S_ARMED) && arm_i && w_hit && capture_waiting_i;
    assign w_miss      = w_hit && (w_busy || ((r_state == S_ARMED) && arm_i && !capture_waiting_i));

    // Sequencer: arm, accept, post-trigger countdown, freeze, wait for readout, holdoff
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= S_DISARMED;
            r_cnt            <= '0;
            r_seen_low       <= 1'b0;
            r_capture_enable <= 1'b1;
            r_trigger        <= 1'b0;
            r_trig_beams     <= '0;
            r_trig_src       <= '0;
        end else begin
            r_trigger <= 1'b0;
            case (r_state)
                S_DISARMED: begin
                    r_capture_enable <= 1'b1;
                    if (arm_i) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    r_capture_enable <= 1'b1;
                    if (!arm_i) begin
                        r_state <= S_DISARMED;
                    end else if (w_accept) begin
                        r_state      <= S_POST;
                        r_cnt        <= posttrig_len_i;
                        r_trigger    <= 1'b1;
                        r_trig_beams <= w_beam_hits;
                        r_trig_src   <= {force_i, |w_beam_hits};
                    end
                end
                S_POST: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_BITS'(1);
                    end else begin
                        r_state          <= S_FROZEN;
                        r_capture_enable <= 1'b0;
                        r_seen_low       <= 1'b0;
                    end
                end
                S_FROZEN: begin
                    // Readout must be seen to start (waiting low) before its completion re-opens capture
                    if (!capture_waiting_i) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_state          <= S_HOLDOFF;
                        r_cnt            <= holdoff_len_i;
                        r_capture_enable <= 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_BITS'(1);
                    end else begin
                        r_state <= arm_i ? S_ARMED : S_DISARMED;
                    end
                end
                default: begin
                    r_state          <= S_DISARMED;
                    r_capture_enable <= 1'b1;
                end
            endcase
        end
    end

    // Statistics: accepted count wraps, missed count saturates, clear beats a coincident increment
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            r_trig_count   <= '0;
            r_missed_count <= '0;
        end else if (clear_counts_i) begin
            r_trig_count   <= '0;
            r_missed_count <= '0;
        end else begin
            if (w_accept) r_trig_count <= r_trig_count + TRIG_COUNT_BITS'(1);
            if (w_miss && (r_missed_count != '1)) r_missed_count <= r_missed_count + MISSED_BITS'(1);
        end
    end

    assign capture_enable_o = r_capture_enable;
    assign trigger_o        = r_trigger;
    assign trig_beams_o     = r_trig_beams;
    assign trig_src_o       = r_trig_src;
    assign state_o          = r_state;
    assign trig_count_o     = r_trig_count;
    assign missed_count_o   = r_missed_count;

endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// Bench for lowampa_capture_ctrl: driver pushes expected trigger records, monitor pops them on trigger_o.
// Latency: monitor measures trigger_o to capture_enable_o fall against L+1.
// Backpressure: missed-trigger model counts hits offered while the controller cannot accept.
module tb_lowampa_capture_ctrl;

    logic        aclk = 1'b0;
    logic        rst_i;
    logic [1:0]  trig_i;
    logic [1:0]  beam_mask_i;
    logic        force_i;
    logic        arm_i;
    logic [15:0] posttrig_len_i;
    logic [15:0] holdoff_len_i;
    logic        clear_counts_i;
    logic        capture_waiting_i;
    logic        capture_enable_o;
    logic        trigger_o;
    logic [1:0]  trig_beams_o;
    logic [1:0]  trig_src_o;
    logic [2:0]  state_o;
    logic [31:0] trig_count_o;
    logic [15:0] missed_count_o;

    lowampa_capture_ctrl #(
        .NBEAMS(2), .CNT_BITS(16), .TRIG_COUNT_BITS(32), .MISSED_BITS(16)
    ) dut (
        .aclk(aclk), .rst_i(rst_i), .trig_i(trig_i), .beam_mask_i(beam_mask_i),
        .force_i(force_i), .arm_i(arm_i), .posttrig_len_i(posttrig_len_i),
        .holdoff_len_i(holdoff_len_i), .clear_counts_i(clear_counts_i),
        .capture_waiting_i(capture_waiting_i), .capture_enable_o(capture_enable_o),
        .trigger_o(trigger_o), .trig_beams_o(trig_beams_o), .trig_src_o(trig_src_o),
        .state_o(state_o), .trig_count_o(trig_count_o), .missed_count_o(missed_count_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  beams;
        logic [1:0]  src;
        logic [31:0] tc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_tc   = 0;
    logic [15:0] exp_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Monitor: every trigger_o pulse must match the oldest expected record, then the freeze latency is timed
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (trigger_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_trigger: got trigger_o=1 expected no acceptance at %0t", $time);
                end else begin
                    exp_t e;
                    int   n;
                    bit   done;
                    bit   aborted;
                    e = exp_q.pop_front();
                    check("trig_beams", 32'(trig_beams_o), 32'(e.beams));
                    check("trig_src", 32'(trig_src_o), 32'(e.src));
                    check("trig_count", trig_count_o, e.tc);
                    n = 0; done = 0; aborted = 0;
                    while (!done) begin
                        @(posedge aclk);
                        #1;
                        n++;
                        if (rst_i) begin
                            done = 1; aborted = 1;
                        end else if (!capture_enable_o) begin
                            done = 1;
                        end else if (n > 500) begin
                            done = 1;
                        end
                    end
                    if (!aborted) check("freeze_latency", 32'(n), 32'(e.lat));
                end
            end
        end
    end

    // One trigger attempt from ARMED; on acceptance runs the full freeze/readout/holdoff sequence
    task automatic do_accept(input logic [1:0] trig, input logic [1:0] mask, input logic frc,
                             input logic [15:0] len, input logic [15:0] hold,
                             input bit inj, input bit arm_low);
        logic [1:0] bh;
        bit         hit;
        int         k;
        exp_t       e;
        bh  = trig & mask;
        hit = (|bh) || frc;
        @(negedge aclk);
        posttrig_len_i = len;
        holdoff_len_i  = hold;
        trig_i = trig; beam_mask_i = mask; force_i = frc;
        if (hit) begin
            exp_tc  = exp_tc + 1;
            e.beams = bh; e.src = {frc, |bh}; e.tc = exp_tc; e.lat = int'(len) + 1;
            exp_q.push_back(e);
        end
        @(negedge aclk);
        trig_i = 2'b00; force_i = 1'b0;
        if (!hit) begin
            check("nohit_state", 32'(state_o), 32'd1);
            check("nohit_trig_count", trig_count_o, exp_tc);
            check("nohit_missed", 32'(missed_count_o), 32'(exp_miss));
            return;
        end
        // Post-trigger window: optional rejected hit, optional disarm
        if (inj) begin force_i = 1'b1; exp_miss = sat_inc(exp_miss); end
        if (arm_low) arm_i = 1'b0;
        @(negedge aclk);
        force_i = 1'b0;
        k = 0;
        while (capture_enable_o && k < 300) begin @(negedge aclk); k++; end
        check("frozen_cap_en", 32'(capture_enable_o), 32'd0);
        check("frozen_state", 32'(state_o), 32'd3);
        // Waiting stays high on entry: must not leave FROZEN
        for (int i = 0; i < 10; i++) begin
            force_i = (inj && i == 3);
            if (inj && i == 3) exp_miss = sat_inc(exp_miss);
            @(negedge aclk);
        end
        force_i = 1'b0;
        check("hold_frozen_state", 32'(state_o), 32'd3);
        check("hold_frozen_cap_en", 32'(capture_enable_o), 32'd0);
        capture_waiting_i = 1'b0;
        @(negedge aclk);
        capture_waiting_i = 1'b1;
        @(negedge aclk);
        check("holdoff_state", 32'(state_o), 32'd4);
        check("holdoff_cap_en", 32'(capture_enable_o), 32'd1);
        for (int i = 0; i <= int'(hold); i++) begin
            force_i = (inj && i == 0);
            if (inj && i == 0) exp_miss = sat_inc(exp_miss);
            @(negedge aclk);
            force_i = 1'b0;
            if (i == int'(hold) - 1) check("holdoff_last_state", 32'(state_o), 32'd4);
        end
        check("rearm_state", 32'(state_o), arm_low ? 32'd0 : 32'd1);
        check("seq_missed", 32'(missed_count_o), 32'(exp_miss));
        check("seq_trig_count", trig_count_o, exp_tc);
        if (arm_low) begin
            arm_i = 1'b1;
            @(negedge aclk);
            check("rearm_after_disarm", 32'(state_o), 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        rst_i = 1'b1; trig_i = 2'b00; beam_mask_i = 2'b11; force_i = 1'b0; arm_i = 1'b0;
        posttrig_len_i = 16'd4; holdoff_len_i = 16'd3; clear_counts_i = 1'b0; capture_waiting_i = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cap_en", 32'(capture_enable_o), 32'd1);
        check("rst_trigger", 32'(trigger_o), 32'd0);
        check("rst_beams", 32'(trig_beams_o), 32'd0);
        check("rst_src", 32'(trig_src_o), 32'd0);
        check("rst_trig_count", trig_count_o, 32'd0);
        check("rst_missed", 32'(missed_count_o), 32'd0);
        rst_i = 1'b0;
        @(negedge aclk);
        check("disarmed_idle", 32'(state_o), 32'd0);
        arm_i = 1'b1;
        @(negedge aclk);
        check("armed_state", 32'(state_o), 32'd1);

        do_accept(2'b01, 2'b11, 1'b0, 16'd4, 16'd3, 1'b1, 1'b0);
        check("three_misses", 32'(missed_count_o), 32'd3);
        do_accept(2'b00, 2'b11, 1'b1, 16'd0, 16'd2, 1'b0, 1'b0);
        do_accept(2'b01, 2'b10, 1'b0, 16'd4, 16'd3, 1'b0, 1'b0);
        do_accept(2'b11, 2'b11, 1'b0, 16'd2, 16'd1, 1'b0, 1'b1);

        for (int it = 0; it < 12; it++) begin
            do_accept(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      16'($urandom_range(0, 12)), 16'($urandom_range(0, 6)),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Engine busy: every hit is missed, counter must saturate
        @(negedge aclk);
        capture_waiting_i = 1'b0; trig_i = 2'b01; beam_mask_i = 2'b11;
        repeat (70000) @(negedge aclk);
        check("sat_missed", 32'(missed_count_o), 32'hFFFF);
        check("sat_state", 32'(state_o), 32'd1);
        check("sat_trig_count", trig_count_o, exp_tc);
        clear_counts_i = 1'b1;
        @(negedge aclk);
        clear_counts_i = 1'b0; trig_i = 2'b00;
        exp_tc = 0; exp_miss = 0;
        check("clear_missed", 32'(missed_count_o), 32'd0);
        check("clear_trig_count", trig_count_o, 32'd0);
        capture_waiting_i = 1'b1;

        // Asynchronous reset in the middle of the post-trigger window
        @(negedge aclk);
        posttrig_len_i = 16'd20; trig_i = 2'b10;
        exp_tc = exp_tc + 1;
        e.beams = 2'b10; e.src = 2'b01; e.tc = exp_tc; e.lat = 21;
        exp_q.push_back(e);
        @(negedge aclk);
        trig_i = 2'b00;
        repeat (2) @(negedge aclk);
        check("post_state", 32'(state_o), 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_cap_en", 32'(capture_enable_o), 32'd1);
        check("async_rst_trigger", 32'(trigger_o), 32'd0);
        check("async_rst_trig_count", trig_count_o, 32'd0);
        check("async_rst_missed", 32'(missed_count_o), 32'd0);
        check("async_rst_beams", 32'(trig_beams_o), 32'd0);
        @(negedge aclk);
        rst_i = 1'b0;
        exp_tc = 0; exp_miss = 0;
        @(negedge aclk);
        check("post_rst_armed", 32'(state_o), 32'd1);
        repeat (3) @(negedge aclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
